// File: rtl/atmega_pcint.sv
// atmega_pcint: pin-change interrupt block (PCMSK / PCIFR / PCICR / PCCAP).
// Each pin passes through a two-flop synchronizer. Its stable level is compared
// with the level from the previous cycle. Enabled pins that change set a latched
// flag and a sticky per-pin capture bit.
// Optional build macro: ATMEGA_PCINT_DEBOUNCE_EN adds a per-pin debounce filter.
// With the macro undefined, the synchronizer output is used directly.
module atmega_pcint #(
    parameter int                    BUS_ADDR_DATA_LEN = 8,
    parameter int                    PORT_WIDTH        = 8,
    parameter int                    BASE_ADDR         = 0,
    parameter int                    PCMSK_ADDR        = 'h00,
    parameter int                    PCIFR_ADDR        = 'h01,
    parameter int                    PCICR_ADDR        = 'h02,
    parameter int                    PCCAP_ADDR        = 'h03,
    parameter logic [PORT_WIDTH-1:0] PINMASK           = PORT_WIDTH'('hFF),
    parameter int                    DEBOUNCE_CYCLES   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [PORT_WIDTH-1:0]        bus_i,
    output logic [PORT_WIDTH-1:0]        bus_o,
    input  logic [PORT_WIDTH-1:0]        pins_i,
    output logic                         int_o,
    input  logic                         int_ack_i
);

    localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCMSK = BUS_ADDR_DATA_LEN'(BASE_ADDR + PCMSK_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCIFR = BUS_ADDR_DATA_LEN'(BASE_ADDR + PCIFR_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCICR = BUS_ADDR_DATA_LEN'(BASE_ADDR + PCICR_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCCAP = BUS_ADDR_DATA_LEN'(BASE_ADDR + PCCAP_ADDR);

    // Reject an out-of-range debounce length at elaboration.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("atmega_pcint: DEBOUNCE_CYCLES must be in 1..255");
    end

    logic [PORT_WIDTH-1:0] s1_q, s1_d;
    logic [PORT_WIDTH-1:0] s2_q, s2_d;
    logic [PORT_WIDTH-1:0] prv_q, prv_d;
    logic [PORT_WIDTH-1:0] pcmsk_q, pcmsk_d;
    logic [PORT_WIDTH-1:0] pccap_q, pccap_d;
    logic                  pcifr_q, pcifr_d;
    logic                  pcicr_q, pcicr_d;
    logic [PORT_WIDTH-1:0] stable;
    logic [PORT_WIDTH-1:0] change;

    logic hit_msk, hit_ifr, hit_icr, hit_cap;

    // Full-width address decode. Accesses that match no register are ignored.
    assign hit_msk = (addr_i == A_PCMSK);
    assign hit_ifr = (addr_i == A_PCIFR);
    assign hit_icr = (addr_i == A_PCICR);
    assign hit_cap = (addr_i == A_PCCAP);

`ifdef ATMEGA_PCINT_DEBOUNCE_EN
    localparam int CW = 8;

    logic [PORT_WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]         cnt_q [PORT_WIDTH];
    logic [CW-1:0]         cnt_d [PORT_WIDTH];

    // Count consecutive cycles where s2 differs from stable. Accept the new level when the count is reached.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < PORT_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= '0;
            // NOTE: the counters form a small flop array (not RAM), so a per-entry reset loop is cheap and keeps the filter deterministic.
            for (int i = 0; i < PORT_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < PORT_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable = stable_q;
`else
    assign stable = s2_q;
`endif

    // Next-state logic for the synchronizer, edge detect and register file. A set wins over a same-cycle clear.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value unassigned and no latch is inferred.
        s1_d    = pins_i & PINMASK;
        s2_d    = s1_q;
        prv_d   = stable;
        change  = (stable ^ prv_q) & pcmsk_q & PINMASK;

        pcmsk_d = pcmsk_q;
        if (wr_i && hit_msk) begin
            pcmsk_d = bus_i & PINMASK;
        end

        pcicr_d = pcicr_q;
        if (wr_i && hit_icr) begin
            pcicr_d = bus_i[0];
        end

        pcifr_d = pcifr_q;
        if ((wr_i && hit_ifr && bus_i[0]) || int_ack_i) begin
            pcifr_d = 1'b0;
        end
        if (|change) begin
            pcifr_d = 1'b1;
        end

        pccap_d = pccap_q;
        if (wr_i && hit_cap) begin
            pccap_d = pccap_q & ~bus_i;
        end
        pccap_d = (pccap_d | change) & PINMASK;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prv_q   <= '0;
            pcmsk_q <= '0;
            pccap_q <= '0;
            pcifr_q <= 1'b0;
            pcicr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, so the s1->s2 chain really is two stages.
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prv_q   <= prv_d;
            pcmsk_q <= pcmsk_d;
            pccap_q <= pccap_d;
            pcifr_q <= pcifr_d;
            pcicr_q <= pcicr_d;
        end
    end

    // Combinational read mux. Returns 0 unless a read hits a register, and is forced to 0 during reset.
    always_comb begin
        bus_o = '0;
        if (rd_i && !rst_i) begin
            if (hit_msk) begin
                bus_o = pcmsk_q & PINMASK;
            end else if (hit_ifr) begin
                bus_o = PORT_WIDTH'(pcifr_q);
            end else if (hit_icr) begin
                bus_o = PORT_WIDTH'(pcicr_q);
            end else if (hit_cap) begin
                bus_o = pccap_q & PINMASK;
            end
        end
    end

    assign int_o = pcifr_q & pcicr_q & ~rst_i;

endmodule

// File: tb/tb_atmega_pcint.sv
// Testbench for atmega_pcint with default parameters.
// Stimulus tasks push expected {int_o, bus_o} for every read into a scoreboard queue.
// A negedge monitor pops each entry and compares it while rd_i is high.
module tb_atmega_pcint;

`ifdef ATMEGA_PCINT_DEBOUNCE_EN
    localparam int X = 4;
`else
    localparam int X = 0;
`endif

    localparam logic [7:0] A_MSK = 8'h00;
    localparam logic [7:0] A_IFR = 8'h01;
    localparam logic [7:0] A_ICR = 8'h02;
    localparam logic [7:0] A_CAP = 8'h03;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       irq;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] addr   = 8'h00;
    logic       wr     = 1'b0;
    logic       rd     = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out;
    logic [7:0] pins   = 8'hA5;
    logic       irq;
    logic       ack    = 1'b0;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    atmega_pcint dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .addr_i    (addr),
        .wr_i      (wr),
        .rd_i      (rd),
        .bus_i     (bus_in),
        .bus_o     (bus_out),
        .pins_i    (pins),
        .int_o     (irq),
        .int_ack_i (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle_start();
        @(posedge clk);
        #1;
        wr  = 1'b0;
        rd  = 1'b0;
        ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_start();
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        cycle_start();
        addr   = a;
        bus_in = d;
        wr     = 1'b1;
    endtask

    task automatic rd_reg(input string name, input logic [7:0] a, input logic [7:0] d, input logic i);
        cycle_start();
        addr = a;
        rd   = 1'b1;
        sb.push_back('{name, d, i});
    endtask

    task automatic ack_pulse();
        cycle_start();
        ack = 1'b1;
    endtask

    task automatic set_pins(input logic [7:0] p);
        cycle_start();
        pins = p;
    endtask

    // Monitor: score each read and check idle/reset output behaviour.
    always @(negedge clk) begin
        if (rd) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected none", bus_out);
            end else begin
                e = sb.pop_front();
                check(e.name, {irq, bus_out}, {e.irq, e.data});
            end
        end else begin
            check("bus_idle_zero", {1'b0, bus_out}, 9'h000);
        end
        if (rst) begin
            check("int_in_reset", {8'h00, irq}, 9'h000);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with nonzero pins; PCMSK=0 so the settling synchronizers must not flag.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(4 + X);
        rd_reg("rst_pcmsk", A_MSK, 8'h00, 1'b0);
        rd_reg("rst_pcifr", A_IFR, 8'h00, 1'b0);
        rd_reg("rst_pcicr", A_ICR, 8'h00, 1'b0);
        rd_reg("rst_pccap", A_CAP, 8'h00, 1'b0);
        rd_reg("unmapped_read", 8'h10, 8'h00, 1'b0);
        set_pins(8'h00);
        idle(4 + X);
        rd_reg("settle_pcifr", A_IFR, 8'h00, 1'b0);

        // Pin 0 rising edge with exact latency.
        wr_reg(A_MSK, 8'h01);
        wr_reg(A_ICR, 8'h01);
        set_pins(8'h01);
        idle(X);
        rd_reg("lat_edge_n",  A_IFR, 8'h00, 1'b0);
        rd_reg("lat_edge_n1", A_IFR, 8'h00, 1'b0);
        rd_reg("lat_edge_n2", A_IFR, 8'h01, 1'b1);
        rd_reg("cap_pin0",    A_CAP, 8'h01, 1'b1);
        rd_reg("pcmsk_rb",    A_MSK, 8'h01, 1'b1);
        rd_reg("pcicr_rb",    A_ICR, 8'h01, 1'b1);
        wr_reg(A_IFR, 8'h00);
        rd_reg("pcifr_wr0",   A_IFR, 8'h01, 1'b1);
        wr_reg(A_IFR, 8'h01);
        rd_reg("pcifr_wr1",   A_IFR, 8'h00, 1'b0);
        wr_reg(A_CAP, 8'h00);
        rd_reg("pccap_wr0",   A_CAP, 8'h01, 1'b0);
        wr_reg(A_CAP, 8'h01);
        rd_reg("pccap_wr1",   A_CAP, 8'h00, 1'b0);
        wr_reg(A_ICR, 8'hFF);
        rd_reg("pcicr_bit0",  A_ICR, 8'h01, 1'b0);

        // All pins toggle with PCMSK=0.
        wr_reg(A_MSK, 8'h00);
        set_pins(8'hFE);
        idle(4 + X);
        rd_reg("msk0_pcifr", A_IFR, 8'h00, 1'b0);
        rd_reg("msk0_pccap", A_CAP, 8'h00, 1'b0);

        // Flag set with PCICR=0, then enable the interrupt.
        wr_reg(A_ICR, 8'h00);
        wr_reg(A_MSK, 8'h08);
        set_pins(8'hF6);
        idle(4 + X);
        rd_reg("icr0_pcifr", A_IFR, 8'h01, 1'b0);
        rd_reg("icr0_pccap", A_CAP, 8'h08, 1'b0);
        wr_reg(A_ICR, 8'h01);
        rd_reg("icr1_int",   A_IFR, 8'h01, 1'b1);
        wr_reg(A_IFR, 8'h01);
        wr_reg(A_CAP, 8'hFF);
        rd_reg("clr_pcifr",  A_IFR, 8'h00, 1'b0);
        rd_reg("clr_pccap",  A_CAP, 8'h00, 1'b0);

        // Acknowledge in the same cycle as a new pin 2 change: set wins.
        wr_reg(A_MSK, 8'h04);
        set_pins(8'hF2);
        idle(4 + X);
        rd_reg("pin2_flag",  A_IFR, 8'h01, 1'b1);
        set_pins(8'hF6);
        idle(X);
        idle(1);
        ack_pulse();
        rd_reg("ack_vs_set", A_IFR, 8'h01, 1'b1);
        rd_reg("pin2_cap",   A_CAP, 8'h04, 1'b1);
        ack_pulse();
        rd_reg("ack_clear",  A_IFR, 8'h00, 1'b0);

        // A write to an unmapped address is ignored.
        wr_reg(8'h04, 8'hFF);
        rd_reg("unmapped_wr", A_MSK, 8'h04, 1'b0);
        rd_reg("unmapped_rd", 8'h04, 8'h00, 1'b0);

        // Reset while the flag is set and all pins are enabled.
        wr_reg(A_MSK, 8'hFF);
        set_pins(8'h0D);
        idle(4 + X);
        rd_reg("pre_rst_flag", A_IFR, 8'h01, 1'b1);
        cycle_start();
        rst  = 1'b1;
        addr = A_IFR;
        rd   = 1'b1;
        sb.push_back('{"rd_in_reset", 8'h00, 1'b0});
        cycle_start();
        rst = 1'b0;
        rd_reg("post_rst_pcmsk", A_MSK, 8'h00, 1'b0);
        rd_reg("post_rst_pcifr", A_IFR, 8'h00, 1'b0);
        rd_reg("post_rst_pcicr", A_ICR, 8'h00, 1'b0);
        rd_reg("post_rst_pccap", A_CAP, 8'h00, 1'b0);

`ifdef ATMEGA_PCINT_DEBOUNCE_EN
        // A 2-cycle glitch is filtered; a 6-cycle pulse is accepted.
        idle(10);
        wr_reg(A_MSK, 8'h01);
        set_pins(8'h0C);
        idle(1);
        set_pins(8'h0D);
        idle(10);
        rd_reg("glitch_filtered", A_IFR, 8'h00, 1'b0);
        set_pins(8'h0C);
        idle(5);
        set_pins(8'h0D);
        idle(12);
        rd_reg("pulse_accepted", A_IFR, 8'h01, 1'b0);
`endif

        idle(2);
        check("scoreboard_drained", 9'(sb.size()), 9'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
